// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: register-file sizes, free-list state encoding,
// retirement-RAT unpack helper and bitmap helpers.
package rename_pkg;

    localparam int PHYS_REGS = 64;
    localparam int PREG_W    = 6;
    localparam int ARCH_REGS = 32;

    typedef enum logic {
        FL_NORMAL  = 1'b0,
        FL_RECOVER = 1'b1
    } fl_state_e;

    // Entry 0 lives in the MSBs of the flattened retirement RAT.
    function automatic logic [PREG_W-1:0] ret_rat_entry(
        input logic [PREG_W*ARCH_REGS-1:0] rat,
        input int                          i
    );
        return rat[PREG_W*(ARCH_REGS-i)-1 -: PREG_W];
    endfunction

    function automatic logic [PREG_W:0] popcount(input logic [PHYS_REGS-1:0] v);
        logic [PREG_W:0] c;
        c = '0;
        for (int k = 0; k < PHYS_REGS; k++)
            c = c + (PREG_W+1)'(v[k]);
        return c;
    endfunction

    // Identity mapping out of reset: arch i -> phys i, so only the upper registers are free.
    function automatic logic [PHYS_REGS-1:0] reset_bitmap();
        logic [PHYS_REGS-1:0] r;
        for (int p = 0; p < PHYS_REGS; p++)
            r[p] = (p >= ARCH_REGS);
        return r;
    endfunction

endpackage

// File: rtl/phys_reg_freelist_if.sv
// Commit-release / rename-allocate handshake bundle for the physical register free list.
interface phys_reg_freelist_if;

    logic                            tFL_release_IN;
    logic [rename_pkg::PREG_W-1:0]   tFL_releaseId_IN;
    logic                            tFL_allocReq_IN;
    logic                            fFL_allocValid_OUT;
    logic [rename_pkg::PREG_W-1:0]   fFL_allocId_OUT;
    logic [rename_pkg::PREG_W:0]     fFL_count_OUT;

    modport master (
        output tFL_release_IN, tFL_releaseId_IN, tFL_allocReq_IN,
        input  fFL_allocValid_OUT, fFL_allocId_OUT, fFL_count_OUT
    );

    modport slave (
        input  tFL_release_IN, tFL_releaseId_IN, tFL_allocReq_IN,
        output fFL_allocValid_OUT, fFL_allocId_OUT, fFL_count_OUT
    );

endinterface

// File: rtl/freelist_prienc.sv
// Lowest-set-bit priority encoder; id is 0 when no bit is set.
module freelist_prienc #(
    parameter int N = 64,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] id_o,
    output logic         any_o
);

    always_comb begin
        id_o = '0;
        for (int i = N-1; i >= 0; i--)
            if (req_i[i]) id_o = W'(i);
    end

    assign any_o = |req_i;

endmodule

// File: rtl/phys_reg_freelist.sv
// Physical register free list: bitmap + count, one release and one allocation per cycle,
// rebuilt from the retirement RAT after a flush. Optional checking under FREELIST_CHECK_EN.
module phys_reg_freelist
    import rename_pkg::*;
(
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          FREEZE,
    phys_reg_freelist_if.slave            fl,
    input  logic                          tFL_flush_IN,
    input  logic                          tFL_copyRetRat_IN,
    input  logic [PREG_W*ARCH_REGS-1:0]   tFL_retRat_IN,
    output logic                          fFL_error_OUT
);

    logic [PHYS_REGS-1:0] bitmap_q, bitmap_d;
    logic [PREG_W:0]      count_q, count_d;
    fl_state_e            state_q, state_d;
    logic                 pending_q, pending_d;

    logic [PREG_W-1:0]    alloc_id;
    logic                 any_free;
    logic                 alloc_valid;
    logic                 alloc_fire;
    logic                 rel_ok;
    logic                 recover_req;
    logic [PREG_W+1:0]    cnt_wide;
    logic [PHYS_REGS-1:0] mapped;
    logic [PHYS_REGS-1:0] rebuilt;

    freelist_prienc #(.N(PHYS_REGS), .W(PREG_W)) u_prienc (
        .req_i (bitmap_q),
        .id_o  (alloc_id),
        .any_o (any_free)
    );

    assign alloc_valid = (state_q == FL_NORMAL) && (count_q != '0) && !FREEZE;
    assign alloc_fire  = fl.tFL_allocReq_IN && alloc_valid;
    assign recover_req = tFL_flush_IN || tFL_copyRetRat_IN || pending_q;

    assign fl.fFL_allocValid_OUT = alloc_valid;
    assign fl.fFL_allocId_OUT    = any_free ? alloc_id : '0;
    assign fl.fFL_count_OUT      = count_q;

`ifdef FREELIST_CHECK_EN
    // A release of an already-free id is dropped rather than corrupting the count.
    assign rel_ok = fl.tFL_release_IN && !bitmap_q[fl.tFL_releaseId_IN];
`else
    assign rel_ok = fl.tFL_release_IN;
`endif

    assign cnt_wide = (PREG_W+2)'(count_q) + (PREG_W+2)'(rel_ok) - (PREG_W+2)'(alloc_fire);

    // Everything the retirement RAT points at is live; the rest is free.
    always_comb begin
        mapped = '0;
        for (int i = 0; i < ARCH_REGS; i++)
            mapped[ret_rat_entry(tFL_retRat_IN, i)] = 1'b1;
    end
    assign rebuilt = ~mapped;

    always_comb begin
        bitmap_d  = bitmap_q;
        count_d   = count_q;
        state_d   = state_q;
        pending_d = pending_q;
        if (FREEZE) begin
            pending_d = pending_q || tFL_flush_IN || tFL_copyRetRat_IN;
        end else begin
            pending_d = 1'b0;
            case (state_q)
                FL_NORMAL: begin
                    // Entering recovery drops this cycle's alloc and release; the rebuild covers both.
                    if (recover_req) begin
                        state_d = FL_RECOVER;
                    end else begin
                        if (alloc_fire) bitmap_d[alloc_id] = 1'b0;
                        if (rel_ok)     bitmap_d[fl.tFL_releaseId_IN] = 1'b1;
                        count_d = cnt_wide[PREG_W:0];
                    end
                end
                FL_RECOVER: begin
                    bitmap_d = rebuilt;
                    count_d  = popcount(rebuilt);
                    state_d  = recover_req ? FL_RECOVER : FL_NORMAL;
                end
                default: state_d = FL_NORMAL;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            bitmap_q  <= reset_bitmap();
            count_q   <= (PREG_W+1)'(PHYS_REGS - ARCH_REGS);
            state_q   <= FL_NORMAL;
            pending_q <= 1'b0;
        end else begin
            bitmap_q  <= bitmap_d;
            count_q   <= count_d;
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

`ifdef FREELIST_CHECK_EN
    logic        err_q;
    logic        rel_dup;
    logic        req_nv;
    logic        cnt_bad;
    logic        apply;
    logic [31:0] cyc_q;

    assign apply   = !FREEZE && (state_q == FL_NORMAL) && !recover_req;
    assign rel_dup = apply && fl.tFL_release_IN && bitmap_q[fl.tFL_releaseId_IN];
    assign req_nv  = !FREEZE && fl.tFL_allocReq_IN && !alloc_valid;
    assign cnt_bad = apply && (cnt_wide > (PREG_W+2)'(PHYS_REGS));

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            err_q <= 1'b0;
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (rel_dup || req_nv || cnt_bad) err_q <= 1'b1;
`ifndef SYNTHESIS
            if (rel_dup)
                $display("phys_reg_freelist: release of free id %0d at cycle %0d", fl.tFL_releaseId_IN, cyc_q);
            if (req_nv)
                $display("phys_reg_freelist: alloc request without valid (id %0d) at cycle %0d", alloc_id, cyc_q);
            if (cnt_bad)
                $display("phys_reg_freelist: count out of range at cycle %0d", cyc_q);
`endif
        end
    end

    assign fFL_error_OUT = err_q;
`else
    assign fFL_error_OUT = 1'b0;
`endif

endmodule
